// File: rtl/bc_game_core_if.sv
// Switch/button inputs and game status outputs of the Bulls-and-Cows engine.
// The master drives the switches and the confirm button; the engine is the slave.
interface bc_game_core_if #(
    parameter int unsigned N_DIGITS     = 4,
    parameter int unsigned DIGIT_W      = 4,
    parameter int unsigned MAX_ATTEMPTS = 10
);
    localparam int unsigned CNT_W = $clog2(N_DIGITS + 1);
    localparam int unsigned AW    = $clog2(MAX_ATTEMPTS + 1);

    logic                         confirma;
    logic [N_DIGITS*DIGIT_W-1:0]  SW;
    logic [2:0]                   state_code;
    logic                         player;
    logic [CNT_W-1:0]             bulls;
    logic [CNT_W-1:0]             cows;
    logic                         result_valid;
    logic                         invalid_pulse;
    logic [AW-1:0]                attempts_p1;
    logic [AW-1:0]                attempts_p2;

    modport master (
        output confirma, SW,
        input  state_code, player, bulls, cows, result_valid, invalid_pulse,
               attempts_p1, attempts_p2
    );

    modport slave (
        input  confirma, SW,
        output state_code, player, bulls, cows, result_valid, invalid_pulse,
               attempts_p1, attempts_p2
    );
endinterface

// File: rtl/bc_game_core.sv
// Two-player Bulls-and-Cows engine: secret setup, alternating guesses,
// one-digit-per-cycle scoring, win/draw detection. Status outputs only.
module bc_game_core #(
    parameter int unsigned N_DIGITS     = 4,
    parameter int unsigned DIGIT_W      = 4,
    parameter int unsigned MAX_ATTEMPTS = 10
) (
    input  logic          clock,
    input  logic          reset,
    bc_game_core_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(N_DIGITS + 1);
    localparam int unsigned AW    = $clog2(MAX_ATTEMPTS + 1);
    localparam int unsigned IDX_W = $clog2(N_DIGITS);
    localparam int unsigned WW    = N_DIGITS * DIGIT_W;
    localparam logic [DIGIT_W-1:0] NULL_DIGIT = '1;

    typedef enum logic [2:0] {
        S_P1_SETUP = 3'd0,
        S_P2_SETUP = 3'd1,
        S_GUESS    = 3'd2,
        S_SCORE    = 3'd3,
        S_SHOW     = 3'd4,
        S_WIN      = 3'd5,
        S_DRAW     = 3'd6
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_confirma_q;
    logic [WW-1:0]      r_secret1, r_secret2, r_guess;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_bulls, r_cows;
    logic [AW-1:0]      r_att1, r_att2;
    logic               r_player, r_invalid;

    logic               w_press, w_sw_valid, w_score_last, w_win, w_draw;
    logic               w_bull, w_cow;
    logic [WW-1:0]      w_target;
    logic [DIGIT_W-1:0] w_gd, w_td;

    assign w_press      = bus.confirma & ~r_confirma_q;
    assign w_target     = r_player ? r_secret1 : r_secret2;
    assign w_score_last = (r_idx == IDX_W'(N_DIGITS - 1));
    assign w_win        = (r_bulls == CNT_W'(N_DIGITS));
    assign w_draw       = (r_att1 == AW'(MAX_ATTEMPTS)) && (r_att2 == AW'(MAX_ATTEMPTS));

    always_comb begin
        w_sw_valid = 1'b1;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (bus.SW[i*DIGIT_W +: DIGIT_W] == NULL_DIGIT) w_sw_valid = 1'b0;
            for (int unsigned j = i + 1; j < N_DIGITS; j++) begin
                if (bus.SW[i*DIGIT_W +: DIGIT_W] == bus.SW[j*DIGIT_W +: DIGIT_W])
                    w_sw_valid = 1'b0;
            end
        end
    end

    // Digit r_idx of the guess against the same position (bull) and all other positions (cow)
    always_comb begin
        w_gd  = '0;
        w_td  = '0;
        w_cow = 1'b0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (IDX_W'(i) == r_idx) begin
                w_gd = r_guess[i*DIGIT_W +: DIGIT_W];
                w_td = w_target[i*DIGIT_W +: DIGIT_W];
            end
        end
        for (int unsigned j = 0; j < N_DIGITS; j++) begin
            if ((IDX_W'(j) != r_idx) && (w_target[j*DIGIT_W +: DIGIT_W] == w_gd))
                w_cow = 1'b1;
        end
        w_bull = (w_gd == w_td);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_P1_SETUP: if (w_press && w_sw_valid) w_state_nxt = S_P2_SETUP;
            S_P2_SETUP: if (w_press && w_sw_valid) w_state_nxt = S_GUESS;
            S_GUESS:    if (w_press && w_sw_valid) w_state_nxt = S_SCORE;
            S_SCORE:    if (w_score_last)          w_state_nxt = S_SHOW;
            S_SHOW: begin
                if (w_press) begin
                    if (w_win)       w_state_nxt = S_WIN;
                    else if (w_draw) w_state_nxt = S_DRAW;
                    else             w_state_nxt = S_GUESS;
                end
            end
            S_WIN, S_DRAW: if (w_press) w_state_nxt = S_P1_SETUP;
            default:    w_state_nxt = S_P1_SETUP;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_P1_SETUP;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_confirma_q <= 1'b0;
            r_secret1    <= '0;
            r_secret2    <= '0;
            r_guess      <= '0;
            r_idx        <= '0;
            r_bulls      <= '0;
            r_cows       <= '0;
            r_att1       <= '0;
            r_att2       <= '0;
            r_player     <= 1'b0;
            r_invalid    <= 1'b0;
        end else begin
            r_confirma_q <= bus.confirma;
            r_invalid    <= 1'b0;
            case (r_state)
                S_P1_SETUP: if (w_press) begin
                    if (w_sw_valid) r_secret1 <= bus.SW;
                    else            r_invalid <= 1'b1;
                end
                S_P2_SETUP: if (w_press) begin
                    if (w_sw_valid) begin
                        r_secret2 <= bus.SW;
                        r_player  <= 1'b0;
                    end else begin
                        r_invalid <= 1'b1;
                    end
                end
                S_GUESS: if (w_press) begin
                    if (w_sw_valid) begin
                        r_guess <= bus.SW;
                        r_bulls <= '0;
                        r_cows  <= '0;
                        r_idx   <= '0;
                        if (!r_player && r_att1 != AW'(MAX_ATTEMPTS)) r_att1 <= r_att1 + AW'(1);
                        if (r_player && r_att2 != AW'(MAX_ATTEMPTS))  r_att2 <= r_att2 + AW'(1);
                    end else begin
                        r_invalid <= 1'b1;
                    end
                end
                S_SCORE: begin
                    if (w_bull)     r_bulls <= r_bulls + CNT_W'(1);
                    else if (w_cow) r_cows  <= r_cows + CNT_W'(1);
                    r_idx <= w_score_last ? '0 : r_idx + IDX_W'(1);
                end
                S_SHOW: if (w_press && !w_win && !w_draw) r_player <= ~r_player;
                S_WIN, S_DRAW: if (w_press) begin
                    r_secret1 <= '0;
                    r_secret2 <= '0;
                    r_guess   <= '0;
                    r_bulls   <= '0;
                    r_cows    <= '0;
                    r_att1    <= '0;
                    r_att2    <= '0;
                    r_player  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.state_code    = r_state;
    assign bus.player        = r_player;
    assign bus.bulls         = r_bulls;
    assign bus.cows          = r_cows;
    assign bus.result_valid  = (r_state == S_SHOW);
    assign bus.invalid_pulse = r_invalid;
    assign bus.attempts_p1   = r_att1;
    assign bus.attempts_p2   = r_att2;
endmodule

// File: tb/tb_bc_game_core.sv
// Directed bench for bc_game_core: one instance with default limits, one with
// MAX_ATTEMPTS=2 for the draw path.
`timescale 1ns/1ps
module tb_bc_game_core;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bc_game_core_if #(.N_DIGITS(4), .DIGIT_W(4), .MAX_ATTEMPTS(10)) bus0 ();
    bc_game_core_if #(.N_DIGITS(4), .DIGIT_W(4), .MAX_ATTEMPTS(2))  bus1 ();

    bc_game_core #(.N_DIGITS(4), .DIGIT_W(4), .MAX_ATTEMPTS(10)) dut (
        .clock(clk), .reset(rst), .bus(bus0)
    );
    bc_game_core #(.N_DIGITS(4), .DIGIT_W(4), .MAX_ATTEMPTS(2)) dut2 (
        .clock(clk), .reset(rst), .bus(bus1)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic drive(input int sel, input logic c, input logic [15:0] sw);
        if (sel == 0) begin
            bus0.confirma = c;
            bus0.SW       = sw;
        end else begin
            bus1.confirma = c;
            bus1.SW       = sw;
        end
    endtask

    function automatic logic [2:0] st(input int sel);
        return (sel == 0) ? bus0.state_code : bus1.state_code;
    endfunction

    function automatic logic rvf(input int sel);
        return (sel == 0) ? bus0.result_valid : bus1.result_valid;
    endfunction

    // One-cycle press; returns at the falling edge right after the accepting edge
    task automatic press(input int sel, input logic [15:0] sw);
        @(negedge clk); drive(sel, 1'b1, sw);
        @(negedge clk); drive(sel, 1'b0, sw);
    endtask

    // Press a guess, then count cycles until result_valid (bounded)
    task automatic guess(input int sel, input logic [15:0] sw, output int cyc, output int ns);
        @(negedge clk); drive(sel, 1'b1, sw);
        cyc = 0;
        ns  = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); drive(sel, 1'b0, sw);
            cyc++;
            if (st(sel) == 3'd3) ns++;
            if (rvf(sel)) break;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc, ns;
        drive(0, 1'b0, 16'h0000);
        drive(1, 1'b0, 16'h0000);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_state",   bus0.state_code,    3'd0);
        check("rst_player",  bus0.player,        1'b0);
        check("rst_bulls",   bus0.bulls,         3'd0);
        check("rst_cows",    bus0.cows,          3'd0);
        check("rst_att1",    bus0.attempts_p1,   4'd0);
        check("rst_att2",    bus0.attempts_p2,   4'd0);
        check("rst_rv",      bus0.result_valid,  1'b0);
        check("rst_inv",     bus0.invalid_pulse, 1'b0);
        rst = 1'b0;

        // Invalid secrets: repeated digit, then NULL digit
        press(0, 16'h1123);
        check("inv_dup_pulse", bus0.invalid_pulse, 1'b1);
        check("inv_dup_state", bus0.state_code,    3'd0);
        @(negedge clk);
        check("inv_pulse_1cyc", bus0.invalid_pulse, 1'b0);
        press(0, 16'h12F4);
        check("inv_null_pulse", bus0.invalid_pulse, 1'b1);
        check("inv_null_state", bus0.state_code,    3'd0);

        press(0, 16'h1234);
        check("setup1_state", bus0.state_code,    3'd1);
        check("setup1_inv",   bus0.invalid_pulse, 1'b0);
        press(0, 16'h5678);
        check("setup2_state",  bus0.state_code, 3'd2);
        check("setup2_player", bus0.player,     1'b0);

        press(0, 16'h1233);
        check("guess_inv_pulse", bus0.invalid_pulse, 1'b1);
        check("guess_inv_state", bus0.state_code,    3'd2);
        check("guess_inv_att1",  bus0.attempts_p1,   4'd0);

        // P1 vs P2 secret 5678: 5687 -> 2 bulls, 2 cows
        guess(0, 16'h5687, cyc, ns);
        check("g1_latency", cyc, 5);
        check("g1_score_cycles", ns, 4);
        check("g1_bulls", bus0.bulls,       3'd2);
        check("g1_cows",  bus0.cows,        3'd2);
        check("g1_att1",  bus0.attempts_p1, 4'd1);
        check("g1_state", bus0.state_code,  3'd4);

        press(0, 16'h0000);
        check("show1_state",  bus0.state_code,   3'd2);
        check("show1_player", bus0.player,       1'b1);
        check("show1_rv",     bus0.result_valid, 1'b0);

        // P2 holds confirm 20 cycles: 2143 vs P1 secret 1234 -> 0 bulls, 4 cows
        @(negedge clk); drive(0, 1'b1, 16'h2143);
        ns = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus0.state_code == 3'd3) ns++;
        end
        drive(0, 1'b0, 16'h2143);
        check("hold_score_cycles", ns, 4);
        check("hold_att2",  bus0.attempts_p2, 4'd1);
        check("hold_att1",  bus0.attempts_p1, 4'd1);
        check("hold_state", bus0.state_code,  3'd4);
        check("hold_bulls", bus0.bulls,       3'd0);
        check("hold_cows",  bus0.cows,        3'd4);

        press(0, 16'h0000);
        check("show2_player", bus0.player, 1'b0);
        guess(0, 16'h8765, cyc, ns);
        check("g3_bulls", bus0.bulls,       3'd0);
        check("g3_cows",  bus0.cows,        3'd4);
        check("g3_att1",  bus0.attempts_p1, 4'd2);
        press(0, 16'h0000);
        check("show3_player", bus0.player, 1'b1);

        guess(0, 16'h1234, cyc, ns);
        check("g4_bulls", bus0.bulls,       3'd4);
        check("g4_cows",  bus0.cows,        3'd0);
        check("g4_att2",  bus0.attempts_p2, 4'd2);
        press(0, 16'h0000);
        check("win_state",  bus0.state_code, 3'd5);
        check("win_player", bus0.player,     1'b1);
        check("win_bulls",  bus0.bulls,      3'd4);
        press(0, 16'h0000);
        check("newgame_state",  bus0.state_code,  3'd0);
        check("newgame_player", bus0.player,      1'b0);
        check("newgame_att1",   bus0.attempts_p1, 4'd0);
        check("newgame_att2",   bus0.attempts_p2, 4'd0);
        check("newgame_bulls",  bus0.bulls,       3'd0);
        check("newgame_cows",   bus0.cows,        3'd0);

        // Reset in the middle of scoring
        press(0, 16'h1234);
        press(0, 16'h5678);
        @(negedge clk); drive(0, 1'b1, 16'h5678);
        @(negedge clk); drive(0, 1'b0, 16'h5678);
        check("midscore_state", bus0.state_code, 3'd3);
        @(negedge clk);
        check("midscore_bulls", bus0.bulls, 3'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_state", bus0.state_code,  3'd0);
        check("midrst_bulls", bus0.bulls,       3'd0);
        check("midrst_cows",  bus0.cows,        3'd0);
        check("midrst_att1",  bus0.attempts_p1, 4'd0);
        rst = 1'b0;

        // Draw path with MAX_ATTEMPTS = 2
        press(1, 16'h1234);
        press(1, 16'h5678);
        guess(1, 16'h8765, cyc, ns);
        press(1, 16'h0000);
        check("d1_state", bus1.state_code, 3'd2);
        guess(1, 16'h2143, cyc, ns);
        press(1, 16'h0000);
        guess(1, 16'h8765, cyc, ns);
        check("d3_att1", bus1.attempts_p1, 2'd2);
        check("d3_att2", bus1.attempts_p2, 2'd1);
        press(1, 16'h0000);
        check("d3_state", bus1.state_code, 3'd2);
        guess(1, 16'h2143, cyc, ns);
        check("d4_att2", bus1.attempts_p2, 2'd2);
        check("d4_rv",   bus1.result_valid, 1'b1);
        press(1, 16'h0000);
        check("draw_state", bus1.state_code,   3'd6);
        check("draw_rv",    bus1.result_valid, 1'b0);
        press(1, 16'h0000);
        check("draw_exit_state", bus1.state_code,  3'd0);
        check("draw_exit_att1",  bus1.attempts_p1, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/bc_game_core.md
Name: bc_game_core

Overview:
- Parametrised Bulls-and-Cows game engine for two players on the Nexys-A7 board, replacing the fixed 4-digit game FSM.
- Takes switch words plus a confirm button and runs setup, alternating guesses, sequential per-digit scoring, win and draw.
- Exports status only (state code, player, bulls/cows, attempts, flags); 7-segment text encoding lives in a separate display block.
- Adds over the previous generation: configurable digit count and width, per-guess distinct-digit validation, attempt limit with draw, and single-pulse confirm handling.

Parameters:
- N_DIGITS, 4, digits per secret/guess (2..8).
- DIGIT_W, 4, bits per digit; value 2^DIGIT_W-1 is reserved (NULL) and never legal.
- MAX_ATTEMPTS, 10, guesses allowed per player before draw (1..255).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- confirma  in  1  confirm button, level, already debounced.
- SW  in  N_DIGITS*DIGIT_W  switch word; digit k = SW[(k+1)*DIGIT_W-1 : k*DIGIT_W].
- state_code  out  3  P1_SETUP=0, P2_SETUP=1, GUESS=2, SCORE=3, SHOW=4, WIN=5, DRAW=6.
- player  out  1  0 = P1 guessing, 1 = P2 guessing; in WIN, the winner.
- bulls  out  CNT_W  CNT_W = $clog2(N_DIGITS+1).
- cows  out  CNT_W  cow count.
- result_valid  out  1  high only in SHOW.
- invalid_pulse  out  1  one-cycle pulse when a confirm is rejected.
- attempts_p1, attempts_p2  out  AW each  AW = $clog2(MAX_ATTEMPTS+1); accepted guesses per player.

Behaviour:
- Reset (synchronous, any state, mid-score included) sets:
  - state P1_SETUP, player 0.
  - bulls, cows, attempts, result_valid, invalid_pulse = 0.
  - both secrets and the guess register = 0.
  - confirm history register = 0.
- Press detection:
  - press = confirma & ~confirma_q, where confirma_q is confirma registered.
  - A held button yields exactly one press.
  - Presses in SCORE are discarded, not queued.
- Validity check (combinational on SW): all N_DIGITS digits pairwise distinct and none equal to NULL.
- P1_SETUP:
  - Press with valid SW: latch P1 secret, go to P2_SETUP.
  - Press with invalid SW: invalid_pulse high the next cycle, stay.
- P2_SETUP: same rule; latches P2 secret, then goes to GUESS with player 0.
- GUESS:
  - Press with valid SW: latch guess, increment the current player's attempt counter, clear bulls/cows, go to SCORE.
  - Press with invalid SW: invalid_pulse high next cycle, stay; no attempt is counted.
  - The target is the opponent's secret: player 0 guesses P2's secret, player 1 guesses P1's.
- SCORE:
  - Index i runs 0..N_DIGITS-1, one digit per cycle.
  - If guess[i] == target[i], bulls += 1.
  - Else if guess[i] equals any target[j], j != i, cows += 1.
  - Distinctness guarantees no double count.
  - After N_DIGITS cycles, go to SHOW.
  - Latency: press accepted at edge t; SCORE occupies cycles t+1..t+N_DIGITS; SHOW and result_valid begin at t+N_DIGITS+1.
- SHOW:
  - bulls/cows held stable; result_valid = 1.
  - On press, if bulls == N_DIGITS: go to WIN, player unchanged (it marks the winner).
  - Else if attempts_p1 == MAX_ATTEMPTS and attempts_p2 == MAX_ATTEMPTS: go to DRAW.
  - Otherwise toggle player and go to GUESS.
  - P1 wins immediately on its guess; P2 gets no equalising turn.
- WIN / DRAW: outputs frozen; press clears secrets, counters, bulls/cows and player, then goes to P1_SETUP.
- Counter widths:
  - bulls + cows <= N_DIGITS always.
  - Attempt counters never exceed MAX_ATTEMPTS; they saturate, although the FSM reaches DRAW first.
- Simultaneous reset and press: reset wins.
- SW changes during SCORE have no effect, since the guess is already latched.

Test Plan:
- Reset, then N_DIGITS=4, DIGIT_W=4: press with SW=0x1234, then SW=0x5678 -> state_code 0→1→2, player=0.
- Secret P2=0x5678, P1 guesses 0x5687 -> SCORE for exactly 4 cycles; result_valid rises 5 cycles after the accepted press; bulls=2, cows=2, attempts_p1=1.
- In P1_SETUP, press with SW=0x1123, then SW=0x12F4 -> invalid_pulse one cycle each time, state stays 0, secret unchanged.
- Hold confirma high for 20 cycles in GUESS -> exactly one attempt counted, one SCORE pass.
- Sequence: P1 guesses 0x8765 (bulls 0, cows 4), press, P2 guesses 0x1234 -> bulls=4; press -> WIN with player=1; press -> P1_SETUP with all counters 0.
- MAX_ATTEMPTS=2, four non-winning guesses -> DRAW after the fourth SHOW press. Also assert reset during SCORE -> state 0 and bulls=cows=0 on the next cycle.
